// File: rtl/alu_ctrl_stage_if.sv
// Handshake bundle between decode, the ALU-control stage and the EX stage.
// The slave modport is the stage's view; master is the surrounding pipeline's view.
interface alu_ctrl_stage_if #(
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned TAG_WIDTH     = 5
);
  logic                     in_valid;
  logic                     in_ready;
  logic [1:0]               ALUOp;
  logic [2:0]               Funct3;
  logic [6:0]               Funct7;
  logic                     Jump;
  logic [TAG_WIDTH-1:0]     in_tag;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPCODE_LENGTH-1:0] Operation;
  logic                     illegal;
  logic [TAG_WIDTH-1:0]     out_tag;

  modport master (
    output in_valid, ALUOp, Funct3, Funct7, Jump, in_tag, flush, out_ready,
    input  in_ready, out_valid, Operation, illegal, out_tag
  );

  modport slave (
    input  in_valid, ALUOp, Funct3, Funct7, Jump, in_tag, flush, out_ready,
    output in_ready, out_valid, Operation, illegal, out_tag
  );
endinterface

// File: rtl/alu_ctrl_stage.sv
// ALU-control stage: decodes ALUOp/Funct3/Funct7/Jump into ALU operation codes
// and buffers {Operation, illegal, tag} in a 2-entry skid FIFO toward EX.
module alu_ctrl_stage #(
  parameter int unsigned OPCODE_LENGTH = 4,
  parameter int unsigned TAG_WIDTH     = 5
) (
  input  logic              clk,
  input  logic              reset,
  alu_ctrl_stage_if.slave   bus
);

  localparam int unsigned DEPTH   = 2;
  localparam int unsigned CNT_W   = 2;

  localparam logic [OPCODE_LENGTH-1:0] OP_AND  = OPCODE_LENGTH'(4'b0000);
  localparam logic [OPCODE_LENGTH-1:0] OP_OR   = OPCODE_LENGTH'(4'b0001);
  localparam logic [OPCODE_LENGTH-1:0] OP_ADD  = OPCODE_LENGTH'(4'b0010);
  localparam logic [OPCODE_LENGTH-1:0] OP_XOR  = OPCODE_LENGTH'(4'b0011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLL  = OPCODE_LENGTH'(4'b0100);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRL  = OPCODE_LENGTH'(4'b0101);
  localparam logic [OPCODE_LENGTH-1:0] OP_SUB  = OPCODE_LENGTH'(4'b0110);
  localparam logic [OPCODE_LENGTH-1:0] OP_SRA  = OPCODE_LENGTH'(4'b0111);
  localparam logic [OPCODE_LENGTH-1:0] OP_BEQ  = OPCODE_LENGTH'(4'b1000);
  localparam logic [OPCODE_LENGTH-1:0] OP_BLT  = OPCODE_LENGTH'(4'b1001);
  localparam logic [OPCODE_LENGTH-1:0] OP_BGE  = OPCODE_LENGTH'(4'b1010);
  localparam logic [OPCODE_LENGTH-1:0] OP_BNE  = OPCODE_LENGTH'(4'b1011);
  localparam logic [OPCODE_LENGTH-1:0] OP_SLT  = OPCODE_LENGTH'(4'b1100);
  localparam logic [OPCODE_LENGTH-1:0] OP_JUMP = OPCODE_LENGTH'(4'b1111);
  localparam logic [OPCODE_LENGTH-1:0] OP_NONE = OPCODE_LENGTH'(4'b0000);

  logic [OPCODE_LENGTH-1:0] dec_op_c;
  logic                     dec_ill_c;
  logic                     f7_alt_c;
  logic                     unused_funct7_c;

  logic [CNT_W-1:0] count_q, count_d;
  logic             head_q, head_d;
  logic             tail_q, tail_d;
  logic             in_ready_q, in_ready_d;

  logic [OPCODE_LENGTH-1:0] op_mem  [DEPTH];
  logic                     ill_mem [DEPTH];
  logic [TAG_WIDTH-1:0]     tag_mem [DEPTH];

  logic out_valid_c;
  logic push_c;
  logic pop_c;

  assign f7_alt_c        = bus.Funct7[5];
  assign unused_funct7_c = ^{bus.Funct7[6], bus.Funct7[4:0]};

  // Instruction-field decode; Jump overrides everything else.
  always_comb begin
    dec_op_c  = OP_NONE;
    dec_ill_c = 1'b0;
    if (bus.Jump) begin
      dec_op_c = OP_JUMP;
    end else begin
      case (bus.ALUOp)
        2'b00: dec_op_c = OP_ADD;
        2'b01: begin
          case (bus.Funct3)
            3'b000:  dec_op_c = OP_BEQ;
            3'b001:  dec_op_c = OP_BNE;
            3'b100:  dec_op_c = OP_BLT;
            3'b101:  dec_op_c = OP_BGE;
            default: dec_ill_c = 1'b1;
          endcase
        end
        default: begin
          // R-type and I-type share the table; only R-type uses Funct7 to pick SUB.
          case (bus.Funct3)
            3'b000:  dec_op_c = (bus.ALUOp == 2'b10 && f7_alt_c) ? OP_SUB : OP_ADD;
            3'b111:  dec_op_c = OP_AND;
            3'b110:  dec_op_c = OP_OR;
            3'b100:  dec_op_c = OP_XOR;
            3'b001:  dec_op_c = OP_SLL;
            3'b101:  dec_op_c = f7_alt_c ? OP_SRA : OP_SRL;
            3'b010:  dec_op_c = OP_SLT;
            default: dec_ill_c = 1'b1;
          endcase
        end
      endcase
    end
  end

  assign out_valid_c = (count_q != '0);
  assign push_c      = bus.in_valid & in_ready_q;
  assign pop_c       = out_valid_c & bus.out_ready;

  // Pointer/count next-state; flush wins over any concurrent push or pop.
  always_comb begin
    count_d    = count_q;
    head_d     = head_q;
    tail_d     = tail_q;
    in_ready_d = in_ready_q;
    if (bus.flush) begin
      count_d    = '0;
      head_d     = 1'b0;
      tail_d     = 1'b0;
      in_ready_d = 1'b1;
    end else begin
      if (push_c) tail_d = ~tail_q;
      if (pop_c)  head_d = ~head_q;
      count_d    = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
      in_ready_d = (count_d != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q    <= '0;
      head_q     <= 1'b0;
      tail_q     <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      in_ready_q <= in_ready_d;
    end
  end

  // Entry storage is not reset; visibility is gated by count.
  always_ff @(posedge clk) begin
    if (push_c && !bus.flush) begin
      op_mem[tail_q]  <= dec_op_c;
      ill_mem[tail_q] <= dec_ill_c;
      tag_mem[tail_q] <= bus.in_tag;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_c;
  assign bus.Operation = out_valid_c ? op_mem[head_q]  : '0;
  assign bus.illegal   = out_valid_c ? ill_mem[head_q] : 1'b0;
  assign bus.out_tag   = out_valid_c ? tag_mem[head_q] : '0;

endmodule

// File: tb/tb_alu_ctrl_stage.sv
// Directed bench for alu_ctrl_stage: decode table, back-pressure, streaming,
// flush and asynchronous reset.
module tb_alu_ctrl_stage;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  alu_ctrl_stage_if #(.OPCODE_LENGTH(4), .TAG_WIDTH(5)) bus ();

  alu_ctrl_stage #(.OPCODE_LENGTH(4), .TAG_WIDTH(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {ALUOp, Funct3, Funct7[5], Jump, Operation, illegal}
  localparam logic [11:0] VEC [19] = '{
    {2'b10, 3'b000, 1'b1, 1'b0, 4'b0110, 1'b0},
    {2'b10, 3'b101, 1'b1, 1'b0, 4'b0111, 1'b0},
    {2'b11, 3'b000, 1'b1, 1'b0, 4'b0010, 1'b0},
    {2'b01, 3'b010, 1'b0, 1'b1, 4'b1111, 1'b0},
    {2'b01, 3'b001, 1'b0, 1'b0, 4'b1011, 1'b0},
    {2'b01, 3'b010, 1'b0, 1'b0, 4'b0000, 1'b1},
    {2'b10, 3'b011, 1'b0, 1'b0, 4'b0000, 1'b1},
    {2'b10, 3'b000, 1'b0, 1'b0, 4'b0010, 1'b0},
    {2'b10, 3'b111, 1'b0, 1'b0, 4'b0000, 1'b0},
    {2'b10, 3'b110, 1'b0, 1'b0, 4'b0001, 1'b0},
    {2'b10, 3'b100, 1'b0, 1'b0, 4'b0011, 1'b0},
    {2'b11, 3'b001, 1'b0, 1'b0, 4'b0100, 1'b0},
    {2'b11, 3'b101, 1'b0, 1'b0, 4'b0101, 1'b0},
    {2'b10, 3'b010, 1'b0, 1'b0, 4'b1100, 1'b0},
    {2'b00, 3'b111, 1'b1, 1'b0, 4'b0010, 1'b0},
    {2'b01, 3'b000, 1'b0, 1'b0, 4'b1000, 1'b0},
    {2'b01, 3'b100, 1'b0, 1'b0, 4'b1001, 1'b0},
    {2'b01, 3'b101, 1'b0, 1'b0, 4'b1010, 1'b0},
    {2'b11, 3'b011, 1'b0, 1'b0, 4'b0000, 1'b1}
  };

  task automatic drive(input logic valid, input logic [1:0] aluop, input logic [2:0] f3,
                       input logic f7b5, input logic jump, input logic [4:0] tag);
    bus.in_valid = valid;
    bus.ALUOp    = aluop;
    bus.Funct3   = f3;
    bus.Funct7   = {1'b0, f7b5, 5'b00000};
    bus.Jump     = jump;
    bus.in_tag   = tag;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
    checks++;
    if (bus.Operation !== 4'b0000) begin errors++; $display("FAIL reset_operation got %b want 0000", bus.Operation); end
    checks++;
    if (bus.illegal !== 1'b0 || bus.out_tag !== 5'd0) begin
      errors++; $display("FAIL reset_ill_tag got %b/%0d want 0/0", bus.illegal, bus.out_tag);
    end
    @(negedge clk);
    reset = 1'b0;
    step();
  endtask

  task automatic test_decode();
    logic [11:0] v;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 19; i++) begin
      v = VEC[i];
      drive(1'b1, v[11:10], v[9:7], v[6], v[5], 5'(i));
      step();
      checks++;
      if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL decode_valid[%0d] got %b want 1", i, bus.out_valid); end
      checks++;
      if (bus.Operation !== v[4:1]) begin errors++; $display("FAIL decode_op[%0d] got %b want %b", i, bus.Operation, v[4:1]); end
      checks++;
      if (bus.illegal !== v[0]) begin errors++; $display("FAIL decode_illegal[%0d] got %b want %b", i, bus.illegal, v[0]); end
      checks++;
      if (bus.out_tag !== 5'(i)) begin errors++; $display("FAIL decode_tag[%0d] got %0d want %0d", i, bus.out_tag, i); end
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 5'd0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Operation !== 4'b0000) begin
      errors++; $display("FAIL decode_drain got %b/%b want 0/0000", bus.out_valid, bus.Operation);
    end
  endtask

  task automatic test_back_pressure();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 5'd3);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd3 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_first got v=%b tag=%0d rdy=%b want 1/3/1", bus.out_valid, bus.out_tag, bus.in_ready);
    end
    drive(1'b1, 2'b10, 3'b110, 1'b0, 1'b0, 5'd7);
    step();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_ready got %b want 0", bus.in_ready); end
    checks++;
    if (bus.out_tag !== 5'd3 || bus.Operation !== 4'b0011) begin
      errors++; $display("FAIL bp_head got tag=%0d op=%b want 3/0011", bus.out_tag, bus.Operation);
    end
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 5'd9);
    step();
    checks++;
    if (bus.out_tag !== 5'd3 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL bp_hold got tag=%0d v=%b rdy=%b want 3/1/0", bus.out_tag, bus.out_valid, bus.in_ready);
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 5'd0);
    bus.out_ready = 1'b1;
    step();
    checks++;
    if (bus.out_tag !== 5'd7 || bus.Operation !== 4'b0001 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_second got tag=%0d op=%b rdy=%b want 7/0001/1", bus.out_tag, bus.Operation, bus.in_ready);
    end
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_empty got %b want 0", bus.out_valid); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 5'(10 + k));
      step();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'(10 + k) || bus.in_ready !== 1'b1) begin
        errors++; $display("FAIL b2b[%0d] got v=%b tag=%0d rdy=%b want 1/%0d/1", k, bus.out_valid, bus.out_tag, bus.in_ready, 10 + k);
      end
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 5'd0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b01, 3'b000, 1'b0, 1'b0, 5'd21);
    step();
    drive(1'b1, 2'b01, 3'b001, 1'b0, 1'b0, 5'd22);
    step();
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_prefill got rdy=%b want 0", bus.in_ready); end
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 5'd23);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_tag !== 5'd0) begin
      errors++; $display("FAIL flush_full got v=%b rdy=%b tag=%0d want 0/1/0", bus.out_valid, bus.in_ready, bus.out_tag);
    end
    // count=1 with concurrent push and pop, all discarded by flush
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 5'd25);
    step();
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b0, 5'd26);
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL flush_push got v=%b rdy=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    drive(1'b1, 2'b10, 3'b111, 1'b0, 1'b0, 5'd24);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd24) begin
      errors++; $display("FAIL flush_fresh got v=%b tag=%0d want 1/24", bus.out_valid, bus.out_tag);
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 5'd0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_drain got %b want 0", bus.out_valid); end
  endtask

  task automatic test_async_reset();
    bus.out_ready = 1'b0;
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 5'd5);
    step();
    drive(1'b1, 2'b00, 3'b000, 1'b0, 1'b1, 5'd6);
    step();
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 5'd0);
    checks++;
    if (bus.Operation !== 4'b1111 || bus.out_tag !== 5'd5) begin
      errors++; $display("FAIL areset_pre got op=%b tag=%0d want 1111/5", bus.Operation, bus.out_tag);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.Operation !== 4'b0000 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL areset_now got v=%b op=%b rdy=%b want 0/0000/1", bus.out_valid, bus.Operation, bus.in_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    drive(1'b1, 2'b10, 3'b100, 1'b0, 1'b0, 5'd9);
    step();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_tag !== 5'd9 || bus.Operation !== 4'b0011) begin
      errors++; $display("FAIL areset_first got v=%b tag=%0d op=%b want 1/9/0011", bus.out_valid, bus.out_tag, bus.Operation);
    end
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 5'd0);
    step();
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_drain got %b want 0", bus.out_valid); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    drive(1'b0, 2'b00, 3'b000, 1'b0, 1'b0, 5'd0);
    test_reset();
    test_decode();
    test_back_pressure();
    test_back_to_back();
    test_flush();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
